muldiv_seq: RTL and testbench

Iterative multiply/divide sequencer that owns the HI/LO register pair for the single-cycle MIPS core. It accepts MULT/MULTU/DIV/DIVU from the decoder and runs a shift-add multiply or restoring divide over WIDTH cycles. While an operation is in flight it asserts a stall when the core issues a dependent MFHI/MFLO/MTHI/MTLO or a second start. It sits beside the ALU in the datapath and replaces the combinational multiplier and the separate Hi/Lo registers.

---
 rtl/muldiv_pkg.sv | 12 +
 rtl/muldiv_iter.sv | 34 +++
 rtl/muldiv_seq.sv | 131 +++++++++++++
 tb/tb_muldiv_seq.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings and sizing for the HI/LO multiply/divide sequencer.
package muldiv_pkg;
  localparam int MD_WIDTH = 32;
  localparam int MD_CNT_W = $clog2(MD_WIDTH);

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, FIX} md_state_t;
endpackage

// File: rtl/muldiv_iter.sv
// One iteration of shift-add multiply or restoring divide on a {hi,lo} accumulator.
// Purely combinational; the sequencer registers acc_nxt every RUN cycle.
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opnd,
  output logic [2*WIDTH-1:0] acc_nxt
);
  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] trial;

  always_comb begin
    sum     = '0;
    rem_sh  = '0;
    trial   = '0;
    acc_nxt = acc;
    if (is_div) begin
      // partial remainder never exceeds 2*divisor, so W+1 bits is enough
      rem_sh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      trial  = rem_sh - {1'b0, opnd};
      if (!trial[WIDTH])
        acc_nxt = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else
        acc_nxt = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else begin
      sum     = acc[0] ? ({1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd})
                       : {1'b0, acc[2*WIDTH-1:WIDTH]};
      acc_nxt = {sum, acc[WIDTH-1:1]};
    end
  end
endmodule

// File: rtl/muldiv_seq.sv
// HI/LO owner running MULT/MULTU/DIV/DIVU iteratively; result WIDTH+2 cycles after start.
// While busy, stall holds the core on any start or HI/LO access; those requests are dropped.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             mfreq,
  input  logic             hilosel,
  input  logic             mthi,
  input  logic             mtlo,
  output logic [WIDTH-1:0] hilo_out,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             divzero
);
  md_state_t             state;
  logic [MD_CNT_W-1:0]   count;
  logic [2*WIDTH-1:0]    acc;
  logic [2*WIDTH-1:0]    acc_nxt;
  logic [WIDTH-1:0]      opnd;
  logic [WIDTH-1:0]      hi;
  logic [WIDTH-1:0]      lo;
  logic                  is_div;
  logic                  neg_q;
  logic                  neg_r;
  logic                  dz;

  logic                  sgn_op;
  logic                  div_op;
  logic                  a_neg;
  logic                  b_neg;
  logic [WIDTH-1:0]      a_mag;
  logic [WIDTH-1:0]      b_mag;
  logic [2*WIDTH-1:0]    prod;
  logic [WIDTH-1:0]      quo;
  logic [WIDTH-1:0]      rem;

  assign sgn_op = !((op == MD_MULTU) || (op == MD_DIVU));
  assign div_op = (op == MD_DIV) || (op == MD_DIVU);
  assign a_neg  = sgn_op & srca[WIDTH-1];
  assign b_neg  = sgn_op & srcb[WIDTH-1];
  assign a_mag  = a_neg ? -srca : srca;
  assign b_mag  = b_neg ? -srcb : srcb;

  // sign fix-up; neg_q doubles as the product sign for multiplies
  assign prod = neg_q ? -acc : acc;
  assign quo  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  assign busy     = (state != IDLE);
  assign stall    = busy & (start | mfreq | mthi | mtlo);
  assign hilo_out = hilosel ? hi : lo;

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .is_div  (is_div),
    .acc     (acc),
    .opnd    (opnd),
    .acc_nxt (acc_nxt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      count   <= '0;
      acc     <= '0;
      opnd    <= '0;
      hi      <= '0;
      lo      <= '0;
      is_div  <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      dz      <= 1'b0;
      done    <= 1'b0;
      divzero <= 1'b0;
    end else begin
      done    <= 1'b0;
      divzero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            count  <= '0;
            is_div <= div_op;
            if (div_op && (srcb == '0)) begin
              // divide by zero skips RUN: FIX passes srca to HI and ones to LO
              acc   <= {srca, {WIDTH{1'b1}}};
              neg_q <= 1'b0;
              neg_r <= 1'b0;
              dz    <= 1'b1;
              state <= FIX;
            end else begin
              acc   <= {{WIDTH{1'b0}}, (div_op ? a_mag : b_mag)};
              opnd  <= div_op ? b_mag : a_mag;
              neg_q <= a_neg ^ b_neg;
              neg_r <= a_neg;
              dz    <= 1'b0;
              state <= RUN;
            end
          end else begin
            if (mthi) hi <= srca;
            if (mtlo) lo <= srca;
          end
        end
        RUN: begin
          acc   <= acc_nxt;
          count <= count + 1'b1;
          if (count == MD_CNT_W'(WIDTH-1)) state <= FIX;
        end
        FIX: begin
          if (is_div) begin
            hi <= rem;
            lo <= quo;
          end else begin
            {hi, lo} <= prod;
          end
          done    <= 1'b1;
          divzero <= dz;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: timing, arithmetic, stalls, HI/LO moves, reset abort.
module tb_muldiv_seq;
  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic        mfreq;
  logic        hilosel;
  logic        mthi;
  logic        mtlo;
  logic [31:0] hilo_out;
  logic        busy;
  logic        stall;
  logic        done;
  logic        divzero;

  int total = 0;
  int bad   = 0;

  muldiv_seq #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .srca     (srca),
    .srcb     (srcb),
    .mfreq    (mfreq),
    .hilosel  (hilosel),
    .mthi     (mthi),
    .mtlo     (mtlo),
    .hilo_out (hilo_out),
    .busy     (busy),
    .stall    (stall),
    .done     (done),
    .divzero  (divzero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  // Start an op, wait (bounded) for done, return done cycle and HI/LO read at that cycle.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int dcyc, output logic dz, output logic [31:0] h, output logic [31:0] l);
    op = o; srca = a; srcb = b; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    dcyc = 0; dz = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done) begin dcyc = c; dz = divzero; break; end
    end
    hilosel = 1'b1; #1 h = hilo_out;
    hilosel = 1'b0; #1 l = hilo_out;
  endtask

  task automatic test_reset;
    logic [31:0] h;
    reset = 1'b0; start = 1'b0; op = 2'b00; srca = '0; srcb = '0;
    mfreq = 1'b1; hilosel = 1'b1; mthi = 1'b0; mtlo = 1'b0;
    #12;
    total++; if ({busy, stall, done, divzero} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags got=%b want=0000", {busy, stall, done, divzero}); end
    h = hilo_out; hilosel = 1'b0; #1;
    total++; if ({h, hilo_out} !== 64'h0) begin
      bad++; $display("FAIL reset_hilo got=%h want=0", {h, hilo_out}); end
    mfreq = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_multu_timing;
    op = 2'b01; srca = 32'hFFFF_FFFF; srcb = 32'hFFFF_FFFF; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int c = 1; c <= 34; c++) begin
      @(negedge clk);
      total++; if (busy !== (c <= 33)) begin
        bad++; $display("FAIL multu_busy cyc=%0d got=%b want=%b", c, busy, (c <= 33)); end
      total++; if (done !== (c == 34)) begin
        bad++; $display("FAIL multu_done cyc=%0d got=%b want=%b", c, done, (c == 34)); end
    end
    hilosel = 1'b1; #1;
    total++; if (hilo_out !== 32'hFFFF_FFFE) begin
      bad++; $display("FAIL multu_hi got=%h want=fffffffe", hilo_out); end
    hilosel = 1'b0; #1;
    total++; if (hilo_out !== 32'h0000_0001) begin
      bad++; $display("FAIL multu_lo got=%h want=00000001", hilo_out); end
  endtask

  task automatic test_vectors;
    logic [1:0]  vo [7];
    logic [31:0] va [7];
    logic [31:0] vb [7];
    logic [31:0] vh [7];
    logic [31:0] vl [7];
    int dcyc; logic dz; logic [31:0] h, l;
    vo = '{2'b00, 2'b11, 2'b10, 2'b10, 2'b00, 2'b10, 2'b01};
    va = '{32'hFFFF_FFFD, 32'd100, 32'hFFFF_FFF9, 32'h8000_0000, 32'h7FFF_FFFF, 32'd7, 32'h0001_0000};
    vb = '{32'd7, 32'd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0001_0000};
    vh = '{32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 32'd1, 32'd1};
    vl = '{32'hFFFF_FFEB, 32'd14, 32'hFFFF_FFFD, 32'h8000_0000, 32'h8000_0001, 32'hFFFF_FFFD, 32'h0};
    for (int i = 0; i < 7; i++) begin
      do_op(vo[i], va[i], vb[i], dcyc, dz, h, l);
      total++; if (dcyc !== 34 || dz !== 1'b0) begin
        bad++; $display("FAIL vec%0d_done cyc=%0d dz=%b want cyc=34 dz=0", i, dcyc, dz); end
      total++; if (h !== vh[i] || l !== vl[i]) begin
        bad++; $display("FAIL vec%0d_hilo got=%h_%h want=%h_%h", i, h, l, vh[i], vl[i]); end
    end
  endtask

  task automatic test_divzero;
    int dcyc; logic dz; logic [31:0] h, l;
    op = 2'b11; srca = 32'h0000_1234; srcb = 32'h0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      total++; if ({busy, done, divzero} !== ((c == 1) ? 3'b100 : 3'b011)) begin
        bad++; $display("FAIL divz_flags cyc=%0d got=%b want=%b", c, {busy, done, divzero},
                        ((c == 1) ? 3'b100 : 3'b011)); end
    end
    hilosel = 1'b1; #1 h = hilo_out; hilosel = 1'b0; #1 l = hilo_out;
    total++; if (h !== 32'h0000_1234 || l !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL divz_hilo got=%h_%h want=00001234_ffffffff", h, l); end
    @(negedge clk);
    total++; if ({done, divzero} !== 2'b00) begin
      bad++; $display("FAIL divz_pulse got=%b want=00", {done, divzero}); end
    do_op(2'b10, 32'hFFFF_FFF9, 32'h0, dcyc, dz, h, l);
    total++; if (dcyc !== 2 || dz !== 1'b1 || h !== 32'hFFFF_FFF9 || l !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL divz_signed cyc=%0d dz=%b hilo=%h_%h want cyc=2 dz=1 fffffff9_ffffffff",
                      dcyc, dz, h, l); end
  endtask

  task automatic test_stall_mf;
    op = 2'b00; srca = 32'd5; srcb = 32'hFFFF_FFFB; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int c = 1; c <= 34; c++) begin
      if (c >= 5) begin mfreq = 1'b1; hilosel = 1'b0; end
      @(negedge clk);
      total++; if (stall !== (c >= 5 && c <= 33)) begin
        bad++; $display("FAIL mf_stall cyc=%0d got=%b want=%b", c, stall, (c >= 5 && c <= 33)); end
      if (c < 34) begin @(posedge clk); #1; end
    end
    #1;
    total++; if (done !== 1'b1 || hilo_out !== 32'hFFFF_FFE7) begin
      bad++; $display("FAIL mf_read done=%b lo=%h want done=1 lo=ffffffe7", done, hilo_out); end
    mfreq = 1'b0;
  endtask

  task automatic test_mt_busy;
    mthi = 1'b1; srca = 32'hAAAA_5555;
    @(posedge clk); #1 mthi = 1'b0; hilosel = 1'b1; #1;
    total++; if (hilo_out !== 32'hAAAA_5555) begin
      bad++; $display("FAIL mthi_idle got=%h want=aaaa5555", hilo_out); end
    op = 2'b01; srca = 32'd2; srcb = 32'd3; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int c = 1; c <= 34; c++) begin
      mthi = (c == 10);
      if (c == 10) srca = 32'h1234_5678;
      @(negedge clk);
      if (c == 10) begin
        total++; if (stall !== 1'b1) begin
          bad++; $display("FAIL mthi_stall got=%b want=1", stall); end
      end
      if (c == 11) begin
        hilosel = 1'b1; #1;
        total++; if (hilo_out !== 32'hAAAA_5555) begin
          bad++; $display("FAIL mthi_busy hi=%h want=aaaa5555", hilo_out); end
      end
      if (c < 34) begin @(posedge clk); #1; end
    end
    mthi = 1'b0;
    hilosel = 1'b1; #1;
    total++; if (done !== 1'b1 || hilo_out !== 32'h0) begin
      bad++; $display("FAIL mt_op_hi done=%b hi=%h want done=1 hi=0", done, hilo_out); end
    hilosel = 1'b0; #1;
    total++; if (hilo_out !== 32'd6) begin
      bad++; $display("FAIL mt_op_lo got=%h want=6", hilo_out); end
  endtask

  task automatic test_start_mtlo;
    mtlo = 1'b1; srca = 32'h0BAD_F00D;
    @(posedge clk); #1 mtlo = 1'b0; hilosel = 1'b0; #1;
    total++; if (hilo_out !== 32'h0BAD_F00D) begin
      bad++; $display("FAIL mtlo_idle got=%h want=0badf00d", hilo_out); end
    op = 2'b01; srca = 32'd9; srcb = 32'd9; start = 1'b1; mtlo = 1'b1;
    @(posedge clk); #1 start = 1'b0; mtlo = 1'b0;
    for (int c = 1; c <= 34; c++) begin
      start = (c >= 5 && c <= 8);
      if (start) begin op = 2'b11; srca = 32'd100; srcb = 32'd7; end
      @(negedge clk);
      if (c == 1) begin
        total++; if (busy !== 1'b1 || hilo_out !== 32'h0BAD_F00D) begin
          bad++; $display("FAIL start_mtlo busy=%b lo=%h want busy=1 lo=0badf00d", busy, hilo_out); end
      end
      if (c >= 5 && c <= 8) begin
        total++; if (stall !== 1'b1) begin
          bad++; $display("FAIL start_busy_stall cyc=%0d got=%b want=1", c, stall); end
      end
      total++; if (done !== (c == 34)) begin
        bad++; $display("FAIL start_busy_done cyc=%0d got=%b want=%b", c, done, (c == 34)); end
      if (c < 34) begin @(posedge clk); #1; end
    end
    start = 1'b0;
    hilosel = 1'b1; #1;
    total++; if (hilo_out !== 32'h0) begin
      bad++; $display("FAIL start_busy_hi got=%h want=0", hilo_out); end
    hilosel = 1'b0; #1;
    total++; if (hilo_out !== 32'd81) begin
      bad++; $display("FAIL start_busy_lo got=%h want=81", hilo_out); end
  endtask

  task automatic test_reset_mid;
    int dcyc; logic dz; logic [31:0] h, l;
    int seen;
    op = 2'b01; srca = 32'hFFFF_FFFF; srcb = 32'd2; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    seen = 0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 10) reset = 1'b0;
      if (c == 12) reset = 1'b1;
      @(negedge clk);
      if (c == 10) begin
        hilosel = 1'b1; #1 h = hilo_out; hilosel = 1'b0; #1 l = hilo_out;
        total++; if (busy !== 1'b0 || h !== 32'h0 || l !== 32'h0) begin
          bad++; $display("FAIL rst_mid busy=%b hilo=%h_%h want busy=0 hilo=0", busy, h, l); end
      end
      if (done) seen++;
      if (c < 40) begin @(posedge clk); #1; end
    end
    total++; if (seen !== 0) begin
      bad++; $display("FAIL rst_no_done got=%0d pulses want=0", seen); end
    do_op(2'b01, 32'd6, 32'd7, dcyc, dz, h, l);
    total++; if (dcyc !== 34 || h !== 32'h0 || l !== 32'd42) begin
      bad++; $display("FAIL rst_after cyc=%0d hilo=%h_%h want cyc=34 0_2a", dcyc, h, l); end
  endtask

  task automatic test_back_to_back;
    int dcyc; logic dz; logic [31:0] h, l;
    do_op(2'b01, 32'd6, 32'd7, dcyc, dz, h, l);
    total++; if (dcyc !== 34 || h !== 32'h0 || l !== 32'd42) begin
      bad++; $display("FAIL b2b_first cyc=%0d hilo=%h_%h want cyc=34 0_2a", dcyc, h, l); end
    // issued from the done cycle of the previous op
    do_op(2'b11, 32'd100, 32'd7, dcyc, dz, h, l);
    total++; if (dcyc !== 34 || h !== 32'd2 || l !== 32'd14) begin
      bad++; $display("FAIL b2b_second cyc=%0d hilo=%h_%h want cyc=34 2_e", dcyc, h, l); end
  endtask

  initial begin
    test_reset;
    test_multu_timing;
    test_vectors;
    test_divzero;
    test_stall_mf;
    test_mt_busy;
    test_start_mtlo;
    test_reset_mid;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
